// File: rtl/sr_bank_if.sv
// Bundles the per-channel set/reset requests and the latch outputs of one sr_bank.
interface sr_bank_if #(
  parameter int N = 4
);
  logic [N-1:0] s;
  logic [N-1:0] r;
  logic [N-1:0] q;
  logic [N-1:0] q_n;
  logic [N-1:0] chg;

  modport master (output s, output r, input q, input q_n, input chg);
  modport slave  (input s, input r, output q, output q_n, output chg);
endinterface

// File: rtl/sr_bank.sv
// sr_bank: N independent SR latches, each with an optional input debounce filter
// and a selectable resolution for the both-asserted command (reset, set or toggle).
module sr_bank #(
  parameter int            N    = 4,
  parameter int            DEB  = 3,
  parameter int            MODE = 0,
  parameter logic [N-1:0]  INIT = '0
) (
  input logic      clk,
  input logic      rst_n,
  sr_bank_if.slave bus
);
  localparam int CW       = (DEB > 0) ? $clog2(DEB + 1) : 1;
  localparam int MODE_EFF = (MODE == 1 || MODE == 2) ? MODE : 0;

  logic [N-1:0] r_q;
  logic [N-1:0] r_chg;
  logic [N-1:0] r_both;
  logic [N-1:0] w_q_nxt;
  logic [N-1:0] w_both_nxt;

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic [1:0] w_raw;
    logic [1:0] w_cmd;
    logic       w_q;

    assign w_raw = {bus.s[gi], bus.r[gi]};

    if (DEB == 0) begin : g_bypass
      assign w_cmd = w_raw;
    end else begin : g_deb
      logic [1:0]    r_samp;
      logic [1:0]    r_cmd;
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nxt;

      always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_raw != r_samp) begin
          w_cnt_nxt = '0;
        end else if (r_cnt != CW'(DEB)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // The filtered pair is acted on by the latch on the same edge the count lands on DEB.
      assign w_cmd = (w_cnt_nxt == CW'(DEB)) ? w_raw : r_cmd;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_samp <= 2'b00;
          r_cmd  <= 2'b00;
          r_cnt  <= '0;
        end else begin
          r_samp <= w_raw;
          r_cmd  <= w_cmd;
          r_cnt  <= w_cnt_nxt;
        end
      end
    end

    always_comb begin
      w_q = r_q[gi];
      case (w_cmd)
        2'b01: w_q = 1'b0;
        2'b10: w_q = 1'b1;
        2'b11: begin
          if (MODE_EFF == 1) begin
            w_q = 1'b1;
          end else if (MODE_EFF == 2) begin
            w_q = r_both[gi] ? r_q[gi] : ~r_q[gi];
          end else begin
            w_q = 1'b0;
          end
        end
        default: w_q = r_q[gi];
      endcase
    end

    assign w_q_nxt[gi]    = w_q;
    assign w_both_nxt[gi] = (w_cmd == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= INIT;
      r_chg  <= '0;
      r_both <= '0;
    end else begin
      r_q    <= w_q_nxt;
      r_chg  <= w_q_nxt ^ r_q;
      r_both <= w_both_nxt;
    end
  end

  assign bus.q   = r_q;
  assign bus.q_n = ~r_q;
  assign bus.chg = r_chg;
endmodule

// File: tb/tb_sr_bank.sv
// Bench for sr_bank: six configurations share one stimulus stream and are compared
// every edge against a run-length reference model, plus hand-derived vectors.
module tb_sr_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_bank_if #(.N(4)) bus0 ();
  sr_bank_if #(.N(4)) bus1 ();
  sr_bank_if #(.N(4)) bus2 ();
  sr_bank_if #(.N(4)) bus3 ();
  sr_bank_if #(.N(1)) bus4 ();
  sr_bank_if #(.N(4)) bus5 ();

  sr_bank #(.N(4), .DEB(3), .MODE(0), .INIT(4'b0000)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sr_bank #(.N(4), .DEB(3), .MODE(1), .INIT(4'b0000)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  sr_bank #(.N(4), .DEB(0), .MODE(2), .INIT(4'b0000)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  sr_bank #(.N(4), .DEB(3), .MODE(0), .INIT(4'b1010)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  sr_bank #(.N(1), .DEB(0), .MODE(0), .INIT(1'b0))    u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  sr_bank #(.N(4), .DEB(1), .MODE(3), .INIT(4'b0101)) u5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  logic [3:0] dq[6];
  logic [3:0] dqn[6];
  logic [3:0] dchg[6];
  assign dq[0] = bus0.q;  assign dqn[0] = bus0.q_n;  assign dchg[0] = bus0.chg;
  assign dq[1] = bus1.q;  assign dqn[1] = bus1.q_n;  assign dchg[1] = bus1.chg;
  assign dq[2] = bus2.q;  assign dqn[2] = bus2.q_n;  assign dchg[2] = bus2.chg;
  assign dq[3] = bus3.q;  assign dqn[3] = bus3.q_n;  assign dchg[3] = bus3.chg;
  assign dq[4] = {3'b000, bus4.q};  assign dqn[4] = {3'b000, bus4.q_n};  assign dchg[4] = {3'b000, bus4.chg};
  assign dq[5] = bus5.q;  assign dqn[5] = bus5.q_n;  assign dchg[5] = bus5.chg;

  // Reference model: a pair takes effect once it has been seen DEB+1 times in a row.
  int         m_deb[6]  = '{3, 3, 0, 3, 0, 1};
  int         m_mode[6] = '{0, 1, 2, 0, 0, 3};
  int         m_nch[6]  = '{4, 4, 4, 4, 1, 4};
  logic [3:0] m_init[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0101};
  logic [1:0] m_pair[6][4];
  int         m_len[6][4];
  logic [1:0] m_cmd[6][4];
  logic [3:0] m_q[6];
  logic [3:0] m_chg[6];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] sv, input logic [3:0] rv);
    for (int d = 0; d < 6; d++) begin
      logic [3:0] oq;
      int         md;
      oq = m_q[d];
      md = (m_mode[d] == 1 || m_mode[d] == 2) ? m_mode[d] : 0;
      if (!rst) begin
        m_q[d]   = m_init[d];
        m_chg[d] = 4'b0000;
        for (int c = 0; c < 4; c++) begin
          m_pair[d][c] = 2'b00;
          m_len[d][c]  = 1;
          m_cmd[d][c]  = 2'b00;
        end
      end else begin
        for (int c = 0; c < m_nch[d]; c++) begin
          logic [1:0] raw;
          logic [1:0] prev;
          raw = {sv[c], rv[c]};
          if (raw == m_pair[d][c]) begin
            if (m_len[d][c] < 1000) m_len[d][c]++;
          end else begin
            m_pair[d][c] = raw;
            m_len[d][c]  = 1;
          end
          prev = m_cmd[d][c];
          if (m_len[d][c] > m_deb[d]) m_cmd[d][c] = raw;
          case (m_cmd[d][c])
            2'b01: m_q[d][c] = 1'b0;
            2'b10: m_q[d][c] = 1'b1;
            2'b11: begin
              if (md == 1)                        m_q[d][c] = 1'b1;
              else if (md == 2 && prev != 2'b11)  m_q[d][c] = ~m_q[d][c];
              else if (md == 0)                   m_q[d][c] = 1'b0;
            end
            default: ;
          endcase
        end
        m_chg[d] = m_q[d] ^ oq;
      end
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] sv, input logic [3:0] rv);
    logic [3:0] mask;
    rst_n  = rst;
    bus0.s = sv; bus0.r = rv;
    bus1.s = sv; bus1.r = rv;
    bus2.s = sv; bus2.r = rv;
    bus3.s = sv; bus3.r = rv;
    bus4.s = sv[0]; bus4.r = rv[0];
    bus5.s = sv; bus5.r = rv;
    @(posedge clk);
    #1;
    model_edge(rst, sv, rv);
    for (int d = 0; d < 6; d++) begin
      mask = (m_nch[d] == 4) ? 4'hF : 4'h1;
      chk($sformatf("model q d%0d", d),   dq[d],   m_q[d] & mask);
      chk($sformatf("model q_n d%0d", d), dqn[d],  ~m_q[d] & mask);
      chk($sformatf("model chg d%0d", d), dchg[d], m_chg[d] & mask);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] q0;
    logic [3:0] c0;
    logic [3:0] q1;
    logic [3:0] c1;
  } vec_t;

  vec_t tv[25];

  initial begin
    logic [3:0] sv;
    logic [3:0] rv;

    // {rst, s, r, q/chg of reset-dominant bank, q/chg of set-dominant bank}
    tv[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[1]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[2]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[3]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[4]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    tv[5]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tv[6]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tv[7]  = '{1'b1, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tv[8]  = '{1'b1, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tv[9]  = '{1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tv[10] = '{1'b1, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tv[11] = '{1'b1, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tv[12] = '{1'b1, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    tv[13] = '{1'b1, 4'b0010, 4'b0000, 4'b0011, 4'b0010, 4'b0011, 4'b0010};
    tv[14] = '{1'b1, 4'b0010, 4'b0010, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    tv[15] = '{1'b1, 4'b0010, 4'b0010, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    tv[16] = '{1'b1, 4'b0010, 4'b0010, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    tv[17] = '{1'b1, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
    tv[18] = '{1'b1, 4'b0010, 4'b0010, 4'b0001, 4'b0000, 4'b0011, 4'b0000};
    tv[19] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[20] = '{1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[21] = '{1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[22] = '{1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tv[23] = '{1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010};
    tv[24] = '{1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000};

    for (int i = 0; i < 25; i++) begin
      step(tv[i].rst, tv[i].s, tv[i].r);
      chk($sformatf("tbl%0d q mode0", i),   dq[0],   tv[i].q0);
      chk($sformatf("tbl%0d q_n mode0", i), dqn[0],  ~tv[i].q0);
      chk($sformatf("tbl%0d chg mode0", i), dchg[0], tv[i].c0);
      chk($sformatf("tbl%0d q mode1", i),   dq[1],   tv[i].q1);
      chk($sformatf("tbl%0d chg mode1", i), dchg[1], tv[i].c1);
    end

    // toggle-on-both, no debounce
    step(1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b0100, 4'b0100);
      chk($sformatf("toggle hold%0d q", k), dq[2], 4'b0100);
      chk($sformatf("toggle hold%0d chg", k), dchg[2], (k == 0) ? 4'b0100 : 4'b0000);
    end
    step(1'b1, 4'b0000, 4'b0000);
    chk("toggle release q", dq[2], 4'b0100);
    chk("toggle release chg", dchg[2], 4'b0000);
    step(1'b1, 4'b0100, 4'b0100);
    chk("toggle again q", dq[2], 4'b0000);
    chk("toggle again chg", dchg[2], 4'b0100);
    step(1'b1, 4'b0100, 4'b0100);
    chk("toggle again hold q", dq[2], 4'b0000);
    chk("toggle again hold chg", dchg[2], 4'b0000);

    // reset in the middle of a debounce run
    step(1'b0, 4'b0000, 4'b0000);
    chk("init q", dq[3], 4'b1010);
    chk("init q_n", dqn[3], 4'b0101);
    chk("init q illegal mode bank", dq[5], 4'b0101);
    step(1'b1, 4'b0101, 4'b0000);
    step(1'b1, 4'b0101, 4'b0000);
    chk("partial debounce q", dq[3], 4'b1010);
    step(1'b0, 4'b0101, 4'b0000);
    chk("midreset q", dq[3], 4'b1010);
    chk("midreset q_n", dqn[3], 4'b0101);
    chk("midreset chg", dchg[3], 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 4'b0101, 4'b0000);
      chk($sformatf("post-reset edge%0d q", k), dq[3], (k < 4) ? 4'b1010 : 4'b1111);
      chk($sformatf("post-reset edge%0d chg", k), dchg[3], (k == 4) ? 4'b0101 : 4'b0000);
    end

    // fully random every cycle, with occasional resets
    for (int i = 0; i < 300; i++) begin
      sv = 4'($urandom);
      rv = 4'($urandom);
      step(($urandom_range(0, 63) != 0), sv, rv);
    end

    // slowly varying inputs so debounced banks see stable pairs
    sv = 4'b0000;
    rv = 4'b0000;
    step(1'b0, sv, rv);
    for (int i = 0; i < 600; i++) begin
      sv = sv ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      rv = rv ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      step(($urandom_range(0, 199) != 0), sv, rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_bank.md
SR_BANK -- requirements
Module: sr_bank

Interface
REQ-001 Parameter N, default 4: number of independent SR channels, 1..32.
REQ-002 Parameter DEB, default 3: debounce length in clock cycles, 0..255; 0 = debounce bypassed.
REQ-003 Parameter MODE, default 0: 0 = reset-dominant, 1 = set-dominant, 2 = toggle-on-both.
REQ-004 Parameter INIT, default all-zero: N-bit reset value of q.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 s  input  N  per-channel raw set request, bit i drives channel i.
REQ-008 r  input  N  per-channel raw reset request.
REQ-009 q  output  N  registered channel state.
REQ-010 q_n  output  N  bitwise complement of q, always ~q, no extra latency.
REQ-011 chg  output  N  registered one-cycle pulse, high in the first cycle q[i] shows a new value.

Function
REQ-012 Each channel shall be fully independent; no cross-channel interaction.
REQ-013 Per channel, raw pair {s[i],r[i]} shall be sampled every edge into a sample register.
REQ-014 A per-channel counter, width clog2(DEB+1), shall increment (saturating at DEB) when the new sample equals the previous sample, and clear to 0 when it differs.
REQ-015 Filtered command cmd[i] shall load the sampled pair at the edge where the counter reaches DEB; otherwise it shall hold.
REQ-016 With DEB=0, cmd[i] shall equal the live {s[i],r[i]} combinationally; no sample register or counter is used.
REQ-017 Latency: a pair held stable from before edge 1 shall be acted on at edge DEB+1 (edge 1 when DEB=0).
REQ-018 A pair shorter than DEB+1 stable samples shall never reach cmd (glitch rejection).
REQ-019 cmd=00: q[i] holds.
REQ-020 cmd=01 (r only): q[i] <= 0; cmd=10 (s only): q[i] <= 1.
REQ-021 cmd=11, MODE 0: q[i] <= 0; MODE 1: q[i] <= 1.
REQ-022 cmd=11, MODE 2: q[i] shall invert exactly once on the first edge cmd is 11 after being not-11; while cmd stays 11, q[i] holds (per-channel one-bit "prev-both" flag required).
REQ-023 chg[i] shall be set at an edge where q[i] takes a different value and cleared at every other edge; a set on an already-1 channel produces no pulse.
REQ-024 Simultaneous s and r arriving on different edges shall be treated as a changing pair; debounce restarts at the later edge.
REQ-025 Illegal MODE values (3+) shall behave as MODE 0.

Reset
REQ-026 rst_n=0 at an edge shall force q=INIT, chg=0, all counters=0, all sample registers=00, all cmd=00, all prev-both flags=0, overriding any command that edge.
REQ-027 Reset asserted mid-debounce shall discard the partial count; after release counting restarts from 0.
REQ-028 q_n shall equal ~INIT during and immediately after reset.
REQ-029 The first edge with rst_n=1 is edge 1 for REQ-017 purposes.

Verification
REQ-030 N=4, DEB=3, MODE=0: reset, then s=0001 held -> q=0001 at edge 4, chg=0001 for one cycle only, q_n=1110.
REQ-031 DEB=3: s[1] pulsed high for 2 cycles then low -> q unchanged, chg stays 0.
REQ-032 MODE=0 vs MODE=1, s=r=0010 held from q=0010 then q=0000 -> MODE 0 gives q[1]=0, MODE 1 gives q[1]=1, each at edge DEB+1.
REQ-033 MODE=2, DEB=0, q=0000: s=r=0100 held 5 cycles -> q=0100 after edge 1 and stays; release to 00 then 11 again -> q=0000, chg pulses once per toggle.
REQ-034 INIT=1010, DEB=3: s=0101 held 2 cycles, rst_n=0 one cycle, s still held -> q=1010 after reset edge, then q=1111 exactly 4 edges after rst_n returns high.
REQ-035 DEB=0, N=1: s and r toggled randomly every cycle -> q matches a cycle-accurate reference of REQ-019..REQ-021 with one-edge latency.
